// File: rtl/lib_cpu.sv
// CPU-side bus geometry shared by the responder and its storage.
// Latency: n/a (constants only).
// Backpressure: n/a.
package lib_cpu;
  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;
endpackage

// File: rtl/lib_state.sv
// State encoding for the memory responder FSM.
// Latency: n/a (types only).
// Backpressure: n/a.
package lib_state;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_t;
endpackage

// File: rtl/ctrl_bus_if.sv
// Clock and reset bundle delivered to the responder.
// Latency: n/a (wires only).
// Backpressure: n/a.
interface ctrl_bus_if;
  logic clk;
  logic reset;
  modport dut (input clk, input reset);
endinterface

// File: rtl/word_ram.sv
// Word-addressed backing store: synchronous write, combinational read, single shared address.
// Latency: write lands on the clock edge; read data follows addr in the same cycle.
// Backpressure: none; contents are deliberately not reset.
module word_ram
  import lib_cpu::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Commit a write on the rising edge; no reset so stored words survive it.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory slave answering one CPU access at a time after WAIT_CYCLES busy cycles.
// Latency: req sampled at end of cycle N gives a one-cycle ready pulse in cycle N+1+WAIT_CYCLES.
// Backpressure: req is ignored outside IDLE (no queuing); a held req is re-sampled in the next IDLE.
module mem_responder
  import lib_cpu::*;
  import lib_state::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 64
) (
  ctrl_bus_if.dut           ctrl_bus,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ready,
  output logic              err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  mem_state_t        state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic              commit;

  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;

  logic              cur_we;
  logic [WORD_W-1:0] cur_addr;
  logic [WORD_W-1:0] cur_wdata;
  logic [WORD_W-1:0] word_num;
  logic              bad;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;
  logic              err_q;

  // With zero wait states the store is touched on the same edge the request
  // is sampled, so the live inputs stand in for the not-yet-latched copy.
  assign cur_we    = (state == IDLE) ? we    : req_we;
  assign cur_addr  = (state == IDLE) ? addr  : req_addr;
  assign cur_wdata = (state == IDLE) ? wdata : req_wdata;

  // Range check on the full word number so out-of-range addresses never alias
  // onto a low word once the index is truncated.
  assign word_num = cur_addr >> BYTE_OFF_W;
  assign bad      = (cur_addr[BYTE_OFF_W-1:0] != '0) ||
                    (word_num >= WORD_W'(DEPTH_WORDS));
  assign ram_we   = commit && cur_we && !bad && !ctrl_bus.reset;

  word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_word_ram (
    .clk   (ctrl_bus.clk),
    .we    (ram_we),
    .addr  (word_num[AW-1:0]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  // State and wait counter registers.
  always_ff @(posedge ctrl_bus.clk or posedge ctrl_bus.reset) begin
    if (ctrl_bus.reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state logic; commit marks the edge that enters RESP.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the request fields when a new access is accepted.
  always_ff @(posedge ctrl_bus.clk or posedge ctrl_bus.reset) begin
    if (ctrl_bus.reset) begin
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else if (state == IDLE && req) begin
      req_we    <= we;
      req_addr  <= addr;
      req_wdata <= wdata;
    end
  end

  // Load the response registers on entry to RESP; writes leave rdata alone.
  always_ff @(posedge ctrl_bus.clk or posedge ctrl_bus.reset) begin
    if (ctrl_bus.reset) begin
      rdata <= '0;
      err_q <= 1'b0;
    end else if (commit) begin
      err_q <= bad;
      if (bad)          rdata <= '0;
      else if (!cur_we) rdata <= ram_rdata;
    end
  end

  assign ready = (state == RESP);
  assign err   = ready && err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with two wait states, one with none.
// Latency: checks exact ready cycle against the request cycle.
// Backpressure: new requests are only issued once the previous response has arrived.
module tb_mem_responder;

  localparam int W_A = 2;
  localparam int W_B = 0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    int          id;
  } exp_t;

  typedef struct {
    int          d;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  ctrl_bus_if cb ();

  logic        req_a, req_b, we;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, err_a, err_b;

  int   checks, errors, cyc;
  exp_t q_a[$];
  exp_t q_b[$];
  vec_t tbl[16];

  mem_responder #(.WAIT_CYCLES(W_A), .DEPTH_WORDS(64)) u_dut_a (
    .ctrl_bus (cb),
    .req      (req_a),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata_a),
    .ready    (ready_a),
    .err      (err_a)
  );

  mem_responder #(.WAIT_CYCLES(W_B), .DEPTH_WORDS(64)) u_dut_b (
    .ctrl_bus (cb),
    .req      (req_b),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata_b),
    .ready    (ready_b),
    .err      (err_b)
  );

  initial begin
    cb.clk = 1'b0;
    forever #5 cb.clk = ~cb.clk;
  end

  always @(posedge cb.clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req_v);
    end
  endtask

  // Scoreboard side: every ready pulse must match the oldest expectation.
  task automatic mon(input int d, input logic rdy, input logic e, input logic [31:0] rd);
    exp_t x;
    int   n;
    n = (d == 0) ? q_a.size() : q_b.size();
    if (rdy !== 1'b1) begin
      chk($sformatf("err_outside_resp dut%0d cyc%0d", d, cyc), {31'd0, e}, 32'd0);
    end else if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ready dut%0d: ready=1 at cycle %0d, required no pulse", d, cyc);
    end else begin
      if (d == 0) x = q_a.pop_front();
      else        x = q_b.pop_front();
      chk($sformatf("ready_cycle dut%0d id%0d", d, x.id), cyc, x.cyc);
      chk($sformatf("rdata dut%0d id%0d", d, x.id), rd, x.rdata);
      chk($sformatf("err dut%0d id%0d", d, x.id), {31'd0, e}, {31'd0, x.err});
    end
  endtask

  always @(negedge cb.clk) begin
    mon(0, ready_a, err_a, rdata_a);
    mon(1, ready_b, err_b, rdata_b);
  end

  task automatic push(input int d, input int c, input logic [31:0] rd, input logic e, input int id);
    exp_t x;
    x.cyc = c; x.rdata = rd; x.err = e; x.id = id;
    if (d == 0) q_a.push_back(x);
    else        q_b.push_back(x);
  endtask

  // Wait until the selected DUT has no response outstanding, then land in an IDLE cycle.
  task automatic wait_idle(input int d);
    int g;
    g = 0;
    do begin
      @(negedge cb.clk);
      g++;
    end while (((d == 0) ? q_a.size() : q_b.size()) != 0 && g < 200);
    if (g >= 200) begin
      checks++;
      errors++;
      $display("FAIL response_timeout dut%0d: still pending after %0d cycles, required 0", d, g);
    end
    @(negedge cb.clk);
  endtask

  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int id);
    wait_idle(d);
    we = w; addr = a; wdata = wd;
    if (d == 0) req_a = 1'b1;
    else        req_b = 1'b1;
    push(d, cyc + 1 + ((d == 0) ? W_A : W_B), er, ee, id);
    @(negedge cb.clk);
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    req_a = 1'b0; req_b = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    cb.reset = 1'b1;

    //   d  we    addr          wdata         rdata         err
    tbl[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hA5A5_0000, 1'b0};
    tbl[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{0, 1'b0, 32'h0000_0012, 32'h0,         32'h0,         1'b1};
    tbl[3]  = '{0, 1'b1, 32'h0000_0014, 32'h1234_5678, 32'h0,         1'b0};
    tbl[4]  = '{0, 1'b0, 32'h0000_0014, 32'h0,         32'h1234_5678, 1'b0};
    tbl[5]  = '{0, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0,         1'b1};
    tbl[6]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_0000, 1'b0};
    tbl[7]  = '{0, 1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 32'hA5A5_0000, 1'b0};
    tbl[8]  = '{0, 1'b0, 32'h0000_00FC, 32'h0,         32'hCAFE_F00D, 1'b0};
    tbl[9]  = '{0, 1'b0, 32'h0000_0101, 32'h0,         32'h0,         1'b1};
    tbl[10] = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1};
    tbl[11] = '{0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[12] = '{0, 1'b1, 32'h0000_0003, 32'h1111_1111, 32'h0,         1'b1};
    tbl[13] = '{0, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_0000, 1'b0};
    tbl[14] = '{1, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 32'h0,         1'b0};
    tbl[15] = '{1, 1'b0, 32'h0000_0020, 32'h0,         32'h0BAD_F00D, 1'b0};

    repeat (3) @(negedge cb.clk);
    chk("reset rdata_a", rdata_a, 32'd0);
    chk("reset ready_a", {31'd0, ready_a}, 32'd0);
    chk("reset err_a",   {31'd0, err_a},   32'd0);
    chk("reset rdata_b", rdata_b, 32'd0);
    chk("reset ready_b", {31'd0, ready_b}, 32'd0);
    cb.reset = 1'b0;

    // Preload word 0, reset, and read it back: the store survives reset.
    issue(0, 1'b1, 32'h0, 32'hA5A5_0000, 32'h0, 1'b0, 100);
    wait_idle(0);
    cb.reset = 1'b1;
    @(negedge cb.clk);
    cb.reset = 1'b0;
    issue(0, 1'b0, 32'h0, 32'h0, 32'hA5A5_0000, 1'b0, 101);

    for (int i = 0; i < 16; i++)
      issue(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].er, tbl[i].ee, i);

    // Zero wait states with req held high: a response every second cycle.
    wait_idle(1);
    we = 1'b0; addr = 32'h20; wdata = '0;
    req_b = 1'b1;
    push(1, cyc + 1, 32'h0BAD_F00D, 1'b0, 200);
    push(1, cyc + 3, 32'h0BAD_F00D, 1'b0, 201);
    push(1, cyc + 5, 32'h0BAD_F00D, 1'b0, 202);
    repeat (6) @(negedge cb.clk);
    req_b = 1'b0;

    // Reset in the first BUSY cycle of a write: abandoned, outputs clear at once.
    wait_idle(0);
    we = 1'b1; addr = 32'h10; wdata = 32'h55;
    req_a = 1'b1;
    @(negedge cb.clk);
    req_a = 1'b0;
    cb.reset = 1'b1;
    #1;
    chk("busy_reset rdata_a", rdata_a, 32'd0);
    chk("busy_reset ready_a", {31'd0, ready_a}, 32'd0);
    chk("busy_reset err_a",   {31'd0, err_a},   32'd0);
    @(negedge cb.clk);
    cb.reset = 1'b0;
    repeat (6) @(negedge cb.clk);
    issue(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 300);

    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge cb.clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: number of BUSY cycles inserted before each response; legal range 0..15.
REQ-002 Parameter DEPTH_WORDS, default 64: number of 32-bit words in the backing store; power of two.
REQ-003 One clock; reset is asynchronous and active-high. Both arrive through the ctrl_bus interface port as ctrl_bus.clk and ctrl_bus.reset.
REQ-004 ctrl_bus.clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 ctrl_bus.reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  1  CPU memory request strobe (mem access cycle).
REQ-007 we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 addr  input  32  byte address; sampled with req.
REQ-009 wdata  input  32  write data; sampled with req.
REQ-010 rdata  output  32  read data; registered.
REQ-011 ready  output  1  one-cycle response pulse.
REQ-012 err  output  1  error flag; valid only while ready=1.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY and RESP. The reset state is IDLE.
REQ-014 IDLE with req=1: latch we/addr/wdata; go to RESP if WAIT_CYCLES=0, else go to BUSY with cnt=WAIT_CYCLES-1. IDLE with req=0: stay in IDLE.
REQ-015 BUSY: if cnt=0, go to RESP; otherwise decrement cnt and stay in BUSY. BUSY SHALL last exactly WAIT_CYCLES cycles.
REQ-016 RESP: ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency: a req sampled at the end of cycle N SHALL produce ready=1 in cycle N+1+WAIT_CYCLES.
REQ-018 While not in IDLE, req SHALL be ignored (no queuing). A req held high through RESP is re-sampled in the next IDLE cycle.
REQ-019 Error condition: latched addr[1:0]≠0 or word index addr[31:2] ≥ DEPTH_WORDS. On error: err=1 during RESP, no store write, rdata loaded with 0.
REQ-020 Valid read: rdata SHALL be loaded from the store at word addr[31:2] on the edge entering RESP.
REQ-021 Valid write: the store word SHALL be updated with wdata on the edge entering RESP; rdata is unchanged.
REQ-022 Outside RESP, rdata SHALL hold its last value, and ready=0, err=0.
REQ-023 A read issued immediately after a write to the same word SHALL return the new data.
REQ-024 The word index SHALL use log2(DEPTH_WORDS) bits after the range check; no wrap-around aliasing of out-of-range addresses.

Reset
REQ-025 Reset values: state=IDLE, cnt=0, rdata=0, ready=0, err=0, latched request fields = 0.
REQ-026 Reset mid-operation (BUSY or RESP) SHALL abandon the request: no write is committed and no ready pulse is issued.
REQ-027 Store contents SHALL NOT be cleared by reset.

Structure
REQ-028 The MEM_STATE enum (IDLE, BUSY, RESP) SHALL live in lib_state.
REQ-029 The word width (32) and the byte-offset width (2) SHALL live in lib_cpu.
REQ-030 The storage array SHALL be a sub-module word_ram with single-port synchronous write and combinational read, parameterised by DEPTH_WORDS.

Verification
REQ-031 Read after reset, WAIT_CYCLES=2: req=1, we=0, addr=0x0 in cycle 0 -> ready=1 in cycle 3, rdata=0 (or the preloaded word), err=0.
REQ-032 Write then read: write 0xDEADBEEF to 0x10, then read 0x10 -> second response has rdata=0xDEADBEEF, and ready pulses are exactly one cycle wide.
REQ-033 Misaligned/out-of-range access: addr=0x12 -> err=1, rdata=0; addr=0x100 with DEPTH_WORDS=64 -> err=1, and a write to it leaves word 0 unchanged (no aliasing).
REQ-034 Zero wait states, WAIT_CYCLES=0: req in cycle 0 -> ready in cycle 1; req held high continuously -> ready every second cycle.
REQ-035 Reset in BUSY: write 0x55 issued, reset asserted in its first BUSY cycle -> no ready pulse, the word keeps its old value, and outputs return to reset values immediately.
